// File: rtl/oled_pkg.sv
// oled_pkg: shared constants and types for the OLED screen compositor.
//   OLED_W / OLED_H / PIX_CNT : panel geometry (96x64, row-major pixel index)
//   PIX_W                     : pixel_index width
//   COL_W                     : column index width (also width of the wipe bound)
//   BLACK                     : colour shown for out-of-range pixel indices
//   chan_state_t              : per-display channel state (IDLE, WIPE)
package oled_pkg;
  localparam int OLED_W  = 96;
  localparam int OLED_H  = 64;
  localparam int PIX_CNT = 6144;
  localparam int PIX_W   = 13;
  localparam int COL_W   = 7;
  localparam logic [15:0] BLACK = 16'h0000;

  typedef enum logic {IDLE = 1'b0, WIPE = 1'b1} chan_state_t;
endpackage

// File: rtl/oled_wipe_channel.sv
// oled_wipe_channel: one display's source selection.
//   Captures the requested source (ignoring out-of-range selects), swaps the
//   displayed source only on frame_begin, and with OLED_WIPE_EN defined plays a
//   left-to-right column wipe from the old source to the new one.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   frame_begin   1-cycle frame start pulse
//   col           current pixel column (only with OLED_WIPE_EN)
//   sel           requested source index
//   src           packed sources, source k = src[16k+15:16k]
//   pix           combinational pixel colour for the current column
//   busy          1 while this channel is wiping
// Build option: OLED_WIPE_EN (undefined = immediate tear-free cut, busy = 0).
module oled_wipe_channel
  import oled_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int SEL_W    = 4,
  parameter int COL_STEP = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_begin,
`ifdef OLED_WIPE_EN
  input  logic [COL_W-1:0]   col,
`endif
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_SRC*16-1:0] src,
  output logic [15:0]        pix,
  output logic               busy
);
  // Table covers every select code so the mux index width matches exactly;
  // codes >= N_SRC are never captured, their BLACK entries are unreachable.
  localparam int N_SLOT = 2 ** SEL_W;
  logic [15:0] src_arr [N_SLOT];

  for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_src
    if (gi < N_SRC) begin : g_used
      assign src_arr[gi] = src[16*gi +: 16];
    end else begin : g_unused
      assign src_arr[gi] = BLACK;
    end
  end

  logic sel_ok;
  assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(N_SRC));

  logic [SEL_W-1:0] pend_reg, pend_next;
  logic [SEL_W-1:0] cur_reg, cur_next;

`ifdef OLED_WIPE_EN
  chan_state_t      state_reg, state_next;
  logic [SEL_W-1:0] old_reg, old_next;
  logic [COL_W-1:0] bound_reg, bound_next;
  logic [COL_W:0]   bound_sum;

  // One bit wider than bound so the end-of-wipe test never wraps.
  assign bound_sum = {1'b0, bound_reg} + (COL_W+1)'(COL_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      cur_reg   <= '0;
      old_reg   <= '0;
      bound_reg <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      cur_reg   <= cur_next;
      old_reg   <= old_next;
      bound_reg <= bound_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    old_next   = old_reg;
    bound_next = bound_reg;
    pend_next  = sel_ok ? sel : pend_reg;
    if (frame_begin) begin
      case (state_reg)
        IDLE: begin
          if (pend_reg != cur_reg) begin
            old_next   = cur_reg;
            cur_next   = pend_reg;
            bound_next = COL_W'(COL_STEP);
            state_next = WIPE;
          end
        end
        WIPE: begin
          // Requests arriving mid-wipe wait in pend until we are back in IDLE.
          if (bound_sum >= (COL_W+1)'(OLED_W)) begin
            state_next = IDLE;
            bound_next = '0;
          end else begin
            bound_next = bound_sum[COL_W-1:0];
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign pix  = (state_reg == WIPE && col >= bound_reg) ? src_arr[old_reg]
                                                        : src_arr[cur_reg];
  assign busy = (state_reg == WIPE);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      cur_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      cur_reg  <= cur_next;
    end
  end

  always_comb begin
    pend_next = sel_ok ? sel : pend_reg;
    cur_next  = cur_reg;
    if (frame_begin && pend_reg != cur_reg) begin
      cur_next = pend_reg;
    end
  end

  assign pix  = src_arr[cur_reg];
  assign busy = 1'b0;
`endif
endmodule

// File: rtl/oled_screen_compositor.sv
// oled_screen_compositor: picks one of N_SRC RGB565 screen sources for each of
// the top and bottom OLEDs, swapping only at frame boundaries.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   frame_begin            1-cycle pulse at frame start
//   pixel_index            current pixel, row-major 96x64
//   sel_top, sel_bot       requested source per display (out-of-range ignored)
//   src_top, src_bot       packed sources, source k = [16k+15:16k]
//   oled_data_top/_bot     registered pixel colour (1 clk after pixel_index)
//   busy                   1 while either display is wiping
// Build option: OLED_WIPE_EN enables the column wipe between screens.
module oled_screen_compositor
  import oled_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int SEL_W    = 4,
  parameter int COL_STEP = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_begin,
  input  logic [12:0]         pixel_index,
  input  logic [SEL_W-1:0]    sel_top,
  input  logic [SEL_W-1:0]    sel_bot,
  input  logic [N_SRC*16-1:0] src_top,
  input  logic [N_SRC*16-1:0] src_bot,
  output logic [15:0]         oled_data_top,
  output logic [15:0]         oled_data_bot,
  output logic                busy
);
  logic [15:0] pix_top, pix_bot;
  logic        busy_top, busy_bot;
  logic        pix_valid;

  assign pix_valid = (pixel_index < PIX_W'(PIX_CNT));

`ifdef OLED_WIPE_EN
  logic [COL_W-1:0] col;
  assign col = COL_W'(pixel_index % PIX_W'(OLED_W));
`endif

  oled_wipe_channel #(.N_SRC(N_SRC), .SEL_W(SEL_W), .COL_STEP(COL_STEP)) u_top (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_begin (frame_begin),
`ifdef OLED_WIPE_EN
    .col         (col),
`endif
    .sel         (sel_top),
    .src         (src_top),
    .pix         (pix_top),
    .busy        (busy_top)
  );

  oled_wipe_channel #(.N_SRC(N_SRC), .SEL_W(SEL_W), .COL_STEP(COL_STEP)) u_bot (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_begin (frame_begin),
`ifdef OLED_WIPE_EN
    .col         (col),
`endif
    .sel         (sel_bot),
    .src         (src_bot),
    .pix         (pix_bot),
    .busy        (busy_bot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oled_data_top <= BLACK;
      oled_data_bot <= BLACK;
    end else begin
      oled_data_top <= pix_valid ? pix_top : BLACK;
      oled_data_bot <= pix_valid ? pix_bot : BLACK;
    end
  end

  assign busy = busy_top | busy_bot;
endmodule
